// File: rtl/signed_seg_display.sv
// Signed 8-bit value to sign + 3 BCD digits via sequential double-dabble,
// scanned onto a 4-digit common-anode seven-segment display.
//
// state   | meaning
// IDLE    | watch VAL for a change from the last converted value
// CAPTURE | latch sign and magnitude, clear BCD accumulator
// SHIFT   | 8 double-dabble add-3/shift steps
// LATCH   | load display digit registers from BCD result
module signed_seg_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] VAL,
    output logic [6:0] SEG,
    output logic       DP,
    output logic [3:0] AN,
    output logic       BUSY
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] MINUS = 7'h3F;

    typedef enum logic [1:0] {IDLE, CAPTURE, SHIFT, LATCH} state_t;

    state_t      state, state_nxt;
    logic [7:0]  last_val;
    logic        last_valid;
    logic        sign;
    logic [7:0]  mag;
    logic [11:0] bcd;
    logic [11:0] bcd_adj;
    logic [19:0] shifted;
    logic [2:0]  shift_cnt;
    logic [6:0]  dig [4];
    logic [CW-1:0] refresh_cnt;
    logic [1:0]  idx;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'h40;
            4'd1:    glyph = 7'h79;
            4'd2:    glyph = 7'h24;
            4'd3:    glyph = 7'h30;
            4'd4:    glyph = 7'h19;
            4'd5:    glyph = 7'h12;
            4'd6:    glyph = 7'h02;
            4'd7:    glyph = 7'h78;
            4'd8:    glyph = 7'h00;
            4'd9:    glyph = 7'h10;
            default: glyph = BLANK;
        endcase
    endfunction

    function automatic logic [3:0] add3(input logic [3:0] n);
        add3 = (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    assign bcd_adj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
    assign shifted = {bcd_adj, mag} << 1;
    assign DP      = 1'b1;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!last_valid || VAL != last_val) state_nxt = CAPTURE;
            CAPTURE: state_nxt = SHIFT;
            SHIFT:   if (shift_cnt == 3'd7) state_nxt = LATCH;
            LATCH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // BUSY is registered from the current state, so it trails the FSM by one cycle.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            BUSY       <= 1'b0;
            last_val   <= 8'h00;
            last_valid <= 1'b0;
            sign       <= 1'b0;
            mag        <= 8'h00;
            bcd        <= 12'h000;
            shift_cnt  <= 3'd0;
            for (int i = 0; i < 4; i++) dig[i] <= BLANK;
        end else begin
            BUSY <= (state != IDLE);
            case (state)
                CAPTURE: begin
                    sign       <= VAL[7];
                    mag        <= VAL[7] ? (~VAL + 8'd1) : VAL;
                    last_val   <= VAL;
                    last_valid <= 1'b1;
                    bcd        <= 12'h000;
                    shift_cnt  <= 3'd0;
                end
                SHIFT: begin
                    bcd       <= shifted[19:8];
                    mag       <= shifted[7:0];
                    shift_cnt <= shift_cnt + 3'd1;
                end
                LATCH: begin
                    dig[3] <= sign ? MINUS : BLANK;
                    dig[2] <= (bcd[11:8] == 4'd0) ? BLANK : glyph(bcd[11:8]);
                    dig[1] <= (bcd[11:4] == 8'd0) ? BLANK : glyph(bcd[7:4]);
                    dig[0] <= glyph(bcd[3:0]);
                end
                default: ;
            endcase
        end
    end

    // Scan runs independently of the converter; AN and SEG update together.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            refresh_cnt <= '0;
            idx         <= 2'd0;
            AN          <= 4'hF;
            SEG         <= BLANK;
        end else begin
            if (refresh_cnt == CNT_LAST) begin
                refresh_cnt <= '0;
                idx         <= idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
            AN  <= ~(4'b0001 << idx);
            SEG <= dig[idx];
        end
    end

endmodule

// File: tb/tb_signed_seg_display.sv
// Directed bench for signed_seg_display with a 4-cycle refresh period.
module tb_signed_seg_display;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] val = 8'h00;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    signed_seg_display #(.REFRESH_DIV(4)) dut (
        .CLK(clk), .RESET(rst_n), .VAL(val),
        .SEG(seg), .DP(dp), .AN(an), .BUSY(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_busy(input logic lvl, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= max; i++) begin
            if (busy === lvl) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    // Captures one full scan as {digit3, digit2, digit1, digit0}.
    task automatic scan_digits(output logic [27:0] d);
        d = 'x;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            case (an)
                4'hE: d[6:0]   = seg;
                4'hD: d[13:7]  = seg;
                4'hB: d[20:14] = seg;
                4'h7: d[27:21] = seg;
                default: ;
            endcase
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        val   = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (an !== 4'hF)   begin errors++; $display("FAIL reset_an: got %h want F", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h want 7F", seg); end
        checks++; if (dp !== 1'b1)   begin errors++; $display("FAIL reset_dp: got %b want 1", dp); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_zero_scan;
        int n;
        logic [1:0] idx;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (an !== 4'hE)   begin errors++; $display("FAIL first_an: got %h want E", an); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_cycle1: got %b want 0", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_cycle2: got %b want 1", busy); end
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            n++;
        end
        checks++; if (n != 10) begin errors++; $display("FAIL busy_len: got %0d want 10", n); end
        while (cyc < 16) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            idx     = 2'((cyc - 1) / 4);
            exp_an  = ~(4'b0001 << idx);
            exp_seg = (idx == 2'd0) ? 7'h40 : 7'h7F;
            checks++;
            if (an !== exp_an || seg !== exp_seg) begin
                errors++;
                $display("FAIL zero_scan cyc %0d: got an=%h seg=%h want an=%h seg=%h", cyc, an, seg, exp_an, exp_seg);
            end
        end
    endtask

    task automatic test_values;
        logic [7:0]  vin [4]  = '{8'h7F, 8'h80, 8'hFB, 8'h0A};
        logic [27:0] vexp [4] = '{{7'h7F, 7'h79, 7'h24, 7'h78},
                                  {7'h3F, 7'h79, 7'h24, 7'h00},
                                  {7'h3F, 7'h7F, 7'h7F, 7'h12},
                                  {7'h7F, 7'h7F, 7'h79, 7'h40}};
        logic [27:0] got;
        bit ok;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            val = vin[k];
            wait_busy(1'b1, 5, ok);
            checks++; if (!ok) begin errors++; $display("FAIL value_busy_rise %h: got timeout want busy=1", vin[k]); end
            wait_busy(1'b0, 20, ok);
            checks++; if (!ok) begin errors++; $display("FAIL value_busy_fall %h: got timeout want busy=0", vin[k]); end
            repeat (2) @(negedge clk);
            scan_digits(got);
            checks++;
            if (got !== vexp[k]) begin
                errors++;
                $display("FAIL value_digits %h: got %h want %h", vin[k], got, vexp[k]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [27:0] got;
        bit ok;
        int guard = 0;
        @(negedge clk);
        while ((cyc % 16) != 5 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        val = 8'h05;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_third_busy: got %b want 1", busy); end
        val = 8'h06;
        repeat (8) @(negedge clk);
        checks++; if (an !== 4'hE)   begin errors++; $display("FAIL b2b_first_an: got %h want E", an); end
        checks++; if (seg !== 7'h12) begin errors++; $display("FAIL b2b_first_digit: got %h want 12", seg); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_gap: got %b want 0", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_burst: got %b want 1", busy); end
        wait_busy(1'b0, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_busy_fall: got timeout want busy=0"); end
        repeat (2) @(negedge clk);
        scan_digits(got);
        checks++;
        if (got !== {7'h7F, 7'h7F, 7'h7F, 7'h02}) begin
            errors++;
            $display("FAIL b2b_final_digits: got %h want %h", got, {7'h7F, 7'h7F, 7'h7F, 7'h02});
        end
    endtask

    task automatic test_reset_mid_shift;
        logic [27:0] got;
        bit ok;
        @(negedge clk);
        val = 8'hC8;
        wait_busy(1'b1, 5, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_busy_rise: got timeout want busy=1"); end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (an !== 4'hF)   begin errors++; $display("FAIL midrst_an: got %h want F", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL midrst_seg: got %h want 7F", seg); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (an !== 4'hE)   begin errors++; $display("FAIL midrst_first_an: got %h want E", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL midrst_blank: got %h want 7F", seg); end
        wait_busy(1'b1, 5, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_reconvert: got timeout want busy=1"); end
        wait_busy(1'b0, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_busy_fall: got timeout want busy=0"); end
        repeat (2) @(negedge clk);
        scan_digits(got);
        checks++;
        if (got !== {7'h3F, 7'h7F, 7'h12, 7'h02}) begin
            errors++;
            $display("FAIL midrst_digits: got %h want %h", got, {7'h3F, 7'h7F, 7'h12, 7'h02});
        end
    endtask

    initial begin
        test_reset;
        test_zero_scan;
        test_values;
        test_back_to_back;
        test_reset_mid_shift;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
